// File: rtl/hs_responder.sv
// hs_responder: responder side of a four-phase req/ack handshake. Accepted
// payloads land in a first-word-fall-through FIFO that a valid/ready consumer
// drains; ack is withheld while the FIFO has no room.
module hs_responder #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ACK_DELAY = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req,
   input  logic [DATA_W-1:0]      req_data,
   output logic                   ack,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err_proto
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned DLY_W = 4;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_SPACE = 2'd1,
      DELAY      = 2'd2,
      ACK        = 2'd3
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [DLY_W-1:0]  dly_q;
   logic [DLY_W-1:0]  dly_d;
   logic              ack_d;
   logic              err_d;
   logic              push_c;
   logic              pop_c;
   logic              space_c;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_d;
   logic [DATA_W-1:0] mem [DEPTH];

   // A pop frees a slot in the same cycle, so a full FIFO can still accept.
   assign pop_c   = out_valid & out_ready;
   assign space_c = (count < CNT_W'(DEPTH)) | pop_c;
   assign count_d = count + CNT_W'(push_c) - CNT_W'(pop_c);
   assign out_data = mem[rd_ptr];

   // Handshake state, delay counter, ack and sticky error registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dly_q     <= '0;
         ack       <= 1'b0;
         err_proto <= 1'b0;
      end else begin
         state_q   <= state_d;
         dly_q     <= dly_d;
         ack       <= ack_d;
         err_proto <= err_d;
      end
   end

   // Next-state, FIFO push and ack decisions.
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      ack_d   = 1'b0;
      err_d   = err_proto;
      push_c  = 1'b0;
      case (state_q)
         IDLE, WAIT_SPACE: begin
            if (req) begin
               if (space_c) begin
                  push_c = 1'b1;
                  if (ACK_DELAY > 0) begin
                     dly_d   = DLY_W'(ACK_DELAY);
                     state_d = DELAY;
                  end else begin
                     state_d = ACK;
                  end
               end else begin
                  state_d = WAIT_SPACE;
               end
            end else if (state_q == WAIT_SPACE) begin
               // Initiator abandoned a request that was never captured.
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         DELAY: begin
            if (!req) begin
               // Request withdrawn before ack; the captured entry stays.
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (dly_q <= DLY_W'(1)) begin
               state_d = ACK;
            end else begin
               dly_d = dly_q - DLY_W'(1);
            end
         end
         ACK: begin
            if (req) begin
               ack_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO storage; contents need no reset since pointers and count do.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= req_data;
      end
   end

   // FIFO pointers, occupancy and non-empty flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count     <= count_d;
         out_valid <= (count_d != '0);
      end
   end

endmodule
